// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard control slice.
//   hz_state_e : hazard controller FSM states (RUN / MUL_BUSY)
//   REG_ZERO   : hard-wired zero register index; never a real dependency
//   MUL_CNT_W  : width of the multiply busy counter (covers MUL_LAT 2..15)
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_e;

    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned MUL_CNT_W = 4;

endpackage

// File: rtl/hazard_cmp.sv
// Single source/stage dependency comparator.
// Ports:
//   src      : source register read by the instruction in ID
//   use_src  : ID instruction really reads src
//   dst      : destination register of the older instruction
//   regwrite : older instruction writes back dst
//   match_c  : combinational dependency flag
module hazard_cmp
    import pipe_pkg::*;
#(
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic          use_src,
    input  logic [RW-1:0] dst,
    input  logic          regwrite,
    output logic          match_c
);

    // Writes to the zero register are discarded, so they never create a dependency.
    assign match_c = use_src && regwrite && (dst != RW'(REG_ZERO)) && (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW interlock, multi-cycle multiply
// occupancy of EX, redirect flushing, and saturating performance counters.
// Build option: define HAZARD_FWD_EN when a forwarding unit is present; then
// only load-use stalls. Without it, any EX or MEM dependency stalls.
// Ports:
//   CLK, RST                   : clock, synchronous active-high reset
//   id_rs/id_rt, id_use_rs/rt  : ID sources and their use flags
//   ex_rd/mem_rd, *_regwrite   : EX / MEM destinations and writeback flags
//   ex_memread                 : EX instruction is a load
//   ex_mul_start               : multiply enters EX this cycle
//   ex_redirect                : taken branch/jump resolved in EX
//   stall                      : PC and IF/ID hold (PC EN, high = hold)
//   hold_idex                  : ID/EX holds its contents
//   flush_ifid, flush_idex     : register loads a bubble at next edge
//   mul_busy                   : multiplier occupying EX
//   stall_cnt, flush_cnt       : saturating stall-cycle / redirect counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned RW      = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CW      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] mem_rd,
    input  logic          ex_regwrite,
    input  logic          mem_regwrite,
    input  logic          ex_memread,
    input  logic          ex_mul_start,
    input  logic          ex_redirect,
    output logic          stall,
    output logic          hold_idex,
    output logic          flush_ifid,
    output logic          flush_idex,
    output logic          mul_busy,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [MUL_CNT_W-1:0] BUSY_LOAD = MUL_CNT_W'(MUL_LAT - 1);

    hz_state_e            state_q, state_d;
    logic [MUL_CNT_W-1:0] busy_q, busy_d;
    logic                 redirect_taken;
    logic                 rs_ex_match, rt_ex_match, rs_mem_match, rt_mem_match;
    logic                 data_hazard;

    // Dependency comparators, one per source/stage pair.
    hazard_cmp #(.RW(RW)) u_cmp_rs_ex (
        .src(id_rs), .use_src(id_use_rs), .dst(ex_rd), .regwrite(ex_regwrite), .match_c(rs_ex_match)
    );
    hazard_cmp #(.RW(RW)) u_cmp_rt_ex (
        .src(id_rt), .use_src(id_use_rt), .dst(ex_rd), .regwrite(ex_regwrite), .match_c(rt_ex_match)
    );
    hazard_cmp #(.RW(RW)) u_cmp_rs_mem (
        .src(id_rs), .use_src(id_use_rs), .dst(mem_rd), .regwrite(mem_regwrite), .match_c(rs_mem_match)
    );
    hazard_cmp #(.RW(RW)) u_cmp_rt_mem (
        .src(id_rt), .use_src(id_use_rt), .dst(mem_rd), .regwrite(mem_regwrite), .match_c(rt_mem_match)
    );

`ifdef HAZARD_FWD_EN
    // Forwarding covers ALU results; only a load in EX cannot be bypassed in time.
    logic unused_mem_match;
    assign unused_mem_match = rs_mem_match | rt_mem_match;
    assign data_hazard      = (rs_ex_match | rt_ex_match) & ex_memread;
`else
    // No bypass: wait until the producer reaches WB (write-first register file).
    logic unused_memread;
    assign unused_memread = ex_memread;
    assign data_hazard    = rs_ex_match | rt_ex_match | rs_mem_match | rt_mem_match;
`endif

    // FSM state and multiply busy counter.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        busy_q  <= busy_d;
    end

    // Next state and pipeline control outputs.
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        stall          = 1'b0;
        hold_idex      = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        mul_busy       = 1'b0;
        redirect_taken = 1'b0;
        if (RST) begin
            state_d    = RUN;
            busy_d     = '0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_redirect) begin
                        // Redirect wins over both load-use and a multiply start.
                        flush_ifid     = 1'b1;
                        flush_idex     = 1'b1;
                        redirect_taken = 1'b1;
                    end else begin
                        if (data_hazard) begin
                            stall      = 1'b1;
                            flush_idex = 1'b1;
                        end
                        if (ex_mul_start) begin
                            state_d = MUL_BUSY;
                            busy_d  = BUSY_LOAD;
                        end
                    end
                end
                MUL_BUSY: begin
                    stall     = 1'b1;
                    hold_idex = 1'b1;
                    mul_busy  = 1'b1;
                    busy_d    = busy_q - MUL_CNT_W'(1);
                    // Leave as the counter reaches zero: MUL_LAT-1 busy cycles in total.
                    if (busy_q <= MUL_CNT_W'(1)) begin
                        state_d = RUN;
                        busy_d  = '0;
                    end
                end
                default: begin
                    state_d = RUN;
                    busy_d  = '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if (redirect_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model. CW is narrowed to 4 so
// counter saturation is reachable.
module tb_hazard_ctrl;

    localparam int unsigned RW      = 5;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          CLK;
    logic          RST;
    logic [RW-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic          id_use_rs, id_use_rt;
    logic          ex_regwrite, mem_regwrite, ex_memread, ex_mul_start, ex_redirect;
    logic          stall, hold_idex, flush_ifid, flush_idex, mul_busy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: remaining multiply stall cycles and counter values.
    int m_busy_left = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    hazard_ctrl #(.RW(RW), .MUL_LAT(MUL_LAT), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
        .ex_mul_start(ex_mul_start), .ex_redirect(ex_redirect),
        .stall(stall), .hold_idex(hold_idex), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .mul_busy(mul_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit dep(input int src, input bit use_s, input int dst, input bit wr);
        return use_s && wr && (dst != 0) && (src == dst);
    endfunction

    function automatic bit model_hazard();
        bit ex_dep, mem_dep;
        ex_dep  = dep(int'(id_rs), id_use_rs, int'(ex_rd), ex_regwrite) ||
                  dep(int'(id_rt), id_use_rt, int'(ex_rd), ex_regwrite);
        mem_dep = dep(int'(id_rs), id_use_rs, int'(mem_rd), mem_regwrite) ||
                  dep(int'(id_rt), id_use_rt, int'(mem_rd), mem_regwrite);
`ifdef HAZARD_FWD_EN
        return ex_dep && ex_memread;
`else
        return ex_dep || mem_dep;
`endif
    endfunction

    // One clock: check control outputs, advance the model over the edge, check counters.
    task automatic cycle();
        bit e_stall, e_hold, e_fi, e_fx, e_busy;
        #1;
        e_stall = 0; e_hold = 0; e_fi = 0; e_fx = 0; e_busy = 0;
        if (RST) begin
            e_fi = 1; e_fx = 1;
        end else if (m_busy_left > 0) begin
            e_stall = 1; e_hold = 1; e_busy = 1;
        end else if (ex_redirect) begin
            e_fi = 1; e_fx = 1;
        end else if (model_hazard()) begin
            e_stall = 1; e_fx = 1;
        end
        check("stall", 32'(stall), 32'(e_stall));
        check("hold_idex", 32'(hold_idex), 32'(e_hold));
        check("flush_ifid", 32'(flush_ifid), 32'(e_fi));
        check("flush_idex", 32'(flush_idex), 32'(e_fx));
        check("mul_busy", 32'(mul_busy), 32'(e_busy));
        @(posedge CLK);
        if (RST) begin
            m_busy_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (m_busy_left > 0) m_busy_left--;
            else if (ex_redirect) begin
                if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
            end else if (ex_mul_start) m_busy_left = MUL_LAT - 1;
        end
        #1;
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = '0; mem_rd = '0; ex_regwrite = 0; mem_regwrite = 0;
        ex_memread = 0; ex_mul_start = 0; ex_redirect = 0;
    endtask

    task automatic do_reset();
        RST = 1; idle_inputs();
        cycle(); cycle();
        RST = 0;
    endtask

    initial begin
        RST = 1;
        idle_inputs();
        cycle();
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_flush_cnt", 32'(flush_cnt), 0);
        do_reset();

        // lw $5 in EX, ID reads $5; next cycle the load moves to MEM.
        id_rs = 5; id_use_rs = 1; ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
        cycle();
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_rd = 5; mem_regwrite = 1;
        cycle();
`ifdef HAZARD_FWD_EN
        check("lu_total_fwd", 32'(stall_cnt), 1);
`else
        check("lu_total_nofwd", 32'(stall_cnt), 2);
`endif
        do_reset();

        // add $0 in EX, ID reads $0: never a hazard.
        id_rs = 0; id_use_rs = 1; ex_rd = 0; ex_regwrite = 1; mem_rd = 0; mem_regwrite = 1;
        cycle(); cycle();
        check("zero_reg_cnt", 32'(stall_cnt), 0);
        do_reset();

        // Multiply: MUL_LAT-1 stall cycles.
        ex_mul_start = 1;
        cycle();
        ex_mul_start = 0;
        for (int i = 0; i < 5; i++) cycle();
        check("mul_stall_cnt", 32'(stall_cnt), 3);
        do_reset();

        // Load-use with redirect in the same cycle: redirect wins.
        id_rs = 5; id_use_rs = 1; ex_rd = 5; ex_regwrite = 1; ex_memread = 1; ex_redirect = 1;
        cycle();
        check("lu_redir_flush_cnt", 32'(flush_cnt), 1);
        check("lu_redir_stall_cnt", 32'(stall_cnt), 0);
        do_reset();

        // Reset in the second MUL_BUSY cycle aborts the multiply.
        ex_mul_start = 1;
        cycle();
        ex_mul_start = 0;
        cycle();
        RST = 1;
        cycle();
        RST = 0;
        cycle();
        check("abort_stall", 32'(stall), 0);
        check("abort_stall_cnt", 32'(stall_cnt), 0);
        do_reset();

        // Continuous load-use: counter saturates at 15.
        id_rt = 3; id_use_rt = 1; ex_rd = 3; ex_regwrite = 1; ex_memread = 1;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_stall_cnt", 32'(stall_cnt), 15);
        do_reset();

        // Random traffic over a small register range to provoke dependencies.
        for (int i = 0; i < 600; i++) begin
            RST          = ($urandom_range(0, 59) == 0);
            id_rs        = RW'($urandom_range(0, 3));
            id_rt        = RW'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom);
            id_use_rt    = 1'($urandom);
            ex_rd        = RW'($urandom_range(0, 3));
            mem_rd       = RW'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom);
            mem_regwrite = 1'($urandom);
            ex_memread   = 1'($urandom);
            ex_mul_start = ($urandom_range(0, 9) == 0);
            ex_redirect  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
